// File: rtl/jtdsp16_sio_rx.sv
// DSP16 serial input port: synchronises the external ick/ild/di pins, shifts
// an 8- or 16-bit word into the ISR and hands it to the CPU-visible SDX register.
module jtdsp16_sio_rx (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        di,
  input  logic        ick,
  input  logic        ild,
  input  logic        ilen16,
  input  logic        lsb_first,
  input  logic        sdx_read,
  output logic [15:0] sdx_dout,
  output logic        ibf,
  output logic        ovr,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        di_s1, di_s2;
  logic        ick_s1, ick_s2, ick_s3;
  logic        ild_s1, ild_s2, ild_s3;
  logic [1:0]  sync_vld;
  logic        ild_arm;
  logic        ild_rise, ick_rise;
  logic        sample, xfer, read_ok;
  logic [3:0]  cnt, last_cnt;
  logic        len_q, lsb_q;
  logic [15:0] isr, isr_nxt, word;

  // ild only counts once it has been seen low after reset, so a pin held
  // high through reset release does not look like a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      di_s1    <= 1'b0;
      di_s2    <= 1'b0;
      ick_s1   <= 1'b0;
      ick_s2   <= 1'b0;
      ick_s3   <= 1'b0;
      ild_s1   <= 1'b0;
      ild_s2   <= 1'b0;
      ild_s3   <= 1'b0;
      sync_vld <= 2'b00;
      ild_arm  <= 1'b0;
    end else begin
      di_s1    <= di;
      di_s2    <= di_s1;
      ick_s1   <= ick;
      ick_s2   <= ick_s1;
      ick_s3   <= ick_s2;
      ild_s1   <= ild;
      ild_s2   <= ild_s1;
      ild_s3   <= ild_s2;
      sync_vld <= {sync_vld[0], 1'b1};
      ild_arm  <= ild_arm | (sync_vld[1] & ~ild_s2);
    end
  end

  assign ild_rise = ild_s2 & ~ild_s3 & ild_arm;
  assign ick_rise = ick_s2 & ~ick_s3;
  assign sample   = (state == SHIFT) & ick_rise & ~ild_rise;
  assign last_cnt = len_q ? 4'd15 : 4'd7;
  assign xfer     = sample & (cnt == last_cnt);
  assign read_ok  = sdx_read & cen;

  always_comb begin
    isr_nxt = isr;
    if (lsb_q) begin
      if (len_q) isr_nxt = {di_s2, isr[15:1]};
      else       isr_nxt = {8'h00, di_s2, isr[7:1]};
    end else begin
      isr_nxt = {isr[14:0], di_s2};
    end
    word = len_q ? isr_nxt : {8'h00, isr_nxt[7:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ild_rise) state_nxt = SHIFT;
      SHIFT:   if (ild_rise) state_nxt = SHIFT;
               else if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  // A transfer beats a concurrent read: ibf stays set and ovr is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isr      <= 16'h0000;
      cnt      <= 4'd0;
      len_q    <= 1'b0;
      lsb_q    <= 1'b0;
      sdx_dout <= 16'h0000;
      ibf      <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      if (ild_rise) begin
        isr   <= 16'h0000;
        cnt   <= 4'd0;
        len_q <= ilen16;
        lsb_q <= lsb_first;
      end else if (sample) begin
        isr <= isr_nxt;
        cnt <= cnt + 4'd1;
      end
      if (xfer) begin
        sdx_dout <= word;
        ibf      <= 1'b1;
        if (ibf && !read_ok) ovr <= 1'b1;
      end else if (read_ok) begin
        ibf <= 1'b0;
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Directed bench for jtdsp16_sio_rx: a table of whole frames plus hand-written
// sequences for latency, restart, read/transfer collision and reset cases.
module tb_jtdsp16_sio_rx;

  logic        rst, clk, cen, di, ick, ild, ilen16, lsb_first, sdx_read;
  logic [15:0] sdx_dout;
  logic        ibf, ovr, busy;
  int          total = 0;
  int          bad = 0;

  jtdsp16_sio_rx dut (
    .rst(rst), .clk(clk), .cen(cen), .di(di), .ick(ick), .ild(ild),
    .ilen16(ilen16), .lsb_first(lsb_first), .sdx_read(sdx_read),
    .sdx_dout(sdx_dout), .ibf(ibf), .ovr(ovr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [15:0] w;
    bit          l16;
    bit          lsb;
    logic [15:0] exp_dout;
    bit          exp_ibf;
    bit          exp_ovr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    di  = b;
    ick = 1'b0;
    negs(3);
    ick = 1'b1;
    negs(3);
  endtask

  task automatic ild_pulse();
    @(negedge clk);
    ild = 1'b1;
    negs(3);
    ild = 1'b0;
    negs(3);
  endtask

  task automatic send_word(input logic [15:0] w, input bit l16, input bit lsb);
    int n;
    n = l16 ? 16 : 8;
    ilen16    = l16;
    lsb_first = lsb;
    ild_pulse();
    for (int i = 0; i < n; i++) send_bit(lsb ? w[i] : w[n-1-i]);
  endtask

  task automatic do_read(input logic cen_v);
    @(negedge clk);
    sdx_read = 1'b1;
    cen      = cen_v;
    @(negedge clk);
    sdx_read = 1'b0;
    cen      = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    vecs[0] = '{1'b1, 16'h005A, 1'b0, 1'b1, 16'h005A, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 16'hC001, 1'b1, 1'b1, 16'hC001, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h0081, 1'b0, 1'b0, 16'h0081, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 16'hF0F0, 1'b0, 1'b0, 16'h00F0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 16'h3C96, 1'b0, 1'b1, 16'h0096, 1'b1, 1'b0};

    rst = 1'b1; cen = 1'b0; di = 1'b0; ick = 1'b0; ild = 1'b0;
    ilen16 = 1'b1; lsb_first = 1'b0; sdx_read = 1'b0;
    negs(3);
    chk("rst_dout", sdx_dout, 16'h0000);
    chk("rst_ibf", {15'd0, ibf}, 16'd0);
    chk("rst_ovr", {15'd0, ovr}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    negs(3);

    // 0xA5C3 MSB first with exact latency on the 16th ick rise
    w = 16'hA5C3;
    ilen16 = 1'b1; lsb_first = 1'b0;
    ild_pulse();
    for (int i = 15; i >= 1; i--) send_bit(w[i]);
    chk("lat_busy", {15'd0, busy}, 16'd1);
    @(negedge clk);
    di = w[0]; ick = 1'b0;
    negs(3);
    ick = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("lat_ibf_early", {15'd0, ibf}, 16'd0);
    @(posedge clk); #1;
    chk("lat_ibf", {15'd0, ibf}, 16'd1);
    chk("lat_dout", sdx_dout, 16'hA5C3);
    chk("lat_ovr", {15'd0, ovr}, 16'd0);
    chk("lat_busy_done", {15'd0, busy}, 16'd0);
    negs(3);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rd) begin
        do_read(1'b1);
        chk($sformatf("v%0d_rd_ibf", v), {15'd0, ibf}, 16'd0);
        chk($sformatf("v%0d_rd_ovr", v), {15'd0, ovr}, 16'd0);
      end
      send_word(vecs[v].w, vecs[v].l16, vecs[v].lsb);
      chk($sformatf("v%0d_dout", v), sdx_dout, vecs[v].exp_dout);
      chk($sformatf("v%0d_ibf", v), {15'd0, ibf}, {15'd0, vecs[v].exp_ibf});
      chk($sformatf("v%0d_ovr", v), {15'd0, ovr}, {15'd0, vecs[v].exp_ovr});
      chk($sformatf("v%0d_busy", v), {15'd0, busy}, 16'd0);
    end

    // overrun, read ignored without cen, then real read clears both flags
    send_word(16'h4321, 1'b1, 1'b0);
    chk("ovr_set", {15'd0, ovr}, 16'd1);
    do_read(1'b0);
    chk("nocen_ibf", {15'd0, ibf}, 16'd1);
    chk("nocen_ovr", {15'd0, ovr}, 16'd1);
    do_read(1'b1);
    chk("read_ibf", {15'd0, ibf}, 16'd0);
    chk("read_ovr", {15'd0, ovr}, 16'd0);

    // restart after 5 bits
    ilen16 = 1'b1; lsb_first = 1'b0;
    ild_pulse();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("abort_ibf_mid", {15'd0, ibf}, 16'd0);
    send_word(16'h00FF, 1'b1, 1'b0);
    chk("abort_dout", sdx_dout, 16'h00FF);
    chk("abort_ibf", {15'd0, ibf}, 16'd1);
    chk("abort_ovr", {15'd0, ovr}, 16'd0);

    // read coincident with transfer of 0x7777 while ibf=1
    w = 16'h7777;
    ild_pulse();
    for (int i = 15; i >= 1; i--) send_bit(w[i]);
    @(negedge clk);
    di = w[0]; ick = 1'b0;
    negs(3);
    ick = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    sdx_read = 1'b1; cen = 1'b1;
    @(posedge clk); #1;
    chk("coll_dout", sdx_dout, 16'h7777);
    chk("coll_ibf", {15'd0, ibf}, 16'd1);
    chk("coll_ovr", {15'd0, ovr}, 16'd0);
    @(negedge clk);
    sdx_read = 1'b0; cen = 1'b0;
    negs(2);
    do_read(1'b1);
    chk("coll_rd_ibf", {15'd0, ibf}, 16'd0);

    // ild and ick rising together in IDLE: frame starts, sample dropped
    ilen16 = 1'b0; lsb_first = 1'b0;
    @(negedge clk);
    ild = 1'b1; ick = 1'b1; di = 1'b1;
    negs(3);
    ild = 1'b0; ick = 1'b0;
    negs(3);
    w = 16'h003C;
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    chk("same_dout", sdx_dout, 16'h003C);
    chk("same_ibf", {15'd0, ibf}, 16'd1);
    do_read(1'b1);

    // config changes mid-frame are ignored
    w = 16'hABCD;
    ilen16 = 1'b1; lsb_first = 1'b0;
    ild_pulse();
    for (int i = 15; i >= 12; i--) send_bit(w[i]);
    ilen16 = 1'b0; lsb_first = 1'b1;
    for (int i = 11; i >= 0; i--) send_bit(w[i]);
    chk("cfg_dout", sdx_dout, 16'hABCD);
    ilen16 = 1'b1; lsb_first = 1'b0;

    // reset mid-frame, then ick activity without ild
    ild_pulse();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_dout", sdx_dout, 16'h0000);
    chk("arst_ibf", {15'd0, ibf}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_bit(i[0]);
      chk($sformatf("post_rst_busy%0d", i), {15'd0, busy}, 16'd0);
      chk($sformatf("post_rst_ibf%0d", i), {15'd0, ibf}, 16'd0);
    end
    chk("post_rst_dout", sdx_dout, 16'h0000);

    // ild held high across reset release is not a frame start
    @(negedge clk);
    ild = 1'b1;
    negs(2);
    rst = 1'b1;
    negs(2);
    rst = 1'b0;
    negs(4);
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    chk("hold_busy", {15'd0, busy}, 16'd0);
    chk("hold_ibf", {15'd0, ibf}, 16'd0);
    @(negedge clk);
    ild = 1'b0;
    negs(3);
    send_word(16'h5555, 1'b1, 1'b0);
    chk("hold_dout", sdx_dout, 16'h5555);
    chk("hold_ibf2", {15'd0, ibf}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtdsp16_sio_rx.md
JTDSP16_SIO_RX -- requirements
Module: jtdsp16_sio_rx

Interface
REQ-001 SHALL have: rst  input  1  asynchronous reset, active-high.
REQ-002 SHALL have: clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have: cen  input  1  CPU clock enable (clk/2 rate); qualifies sdx_read only.
REQ-004 SHALL have: di  input  1  serial data input pin, asynchronous to clk.
REQ-005 SHALL have: ick  input  1  serial input clock pin, asynchronous; high and low phases each at least 2 clk periods.
REQ-006 SHALL have: ild  input  1  serial input load pin, asynchronous; rising edge marks frame start.
REQ-007 SHALL have: ilen16  input  1  word length: 1 = 16 bits, 0 = 8 bits.
REQ-008 SHALL have: lsb_first  input  1  bit order: 1 = LSB first, 0 = MSB first.
REQ-009 SHALL have: sdx_read  input  1  CPU read strobe for the input data register, valid when cen=1.
REQ-010 SHALL have: sdx_dout  output  16  input data register (SDX in).
REQ-011 SHALL have: ibf  output  1  input buffer full flag.
REQ-012 SHALL have: ovr  output  1  sticky overrun flag.
REQ-013 SHALL have: busy  output  1  high while a frame is being shifted in.

Function
REQ-014 SHALL pass di, ick and ild through 2-flop synchronisers on every clk edge; no cen gating; all three share identical delay.
REQ-015 SHALL detect edges on the synchronised signals against a third registered copy; an edge is acted upon in the same clk cycle it is detected.
REQ-016 SHALL use two states: IDLE and SHIFT; busy=1 only in SHIFT.
REQ-017 IDLE: ild rising edge -> SHIFT; bit counter cleared; ilen16 and lsb_first latched for the frame; ISR cleared.
REQ-018 IDLE: ick edges SHALL be ignored.
REQ-019 SHIFT: each synchronised ick rising edge SHALL sample synchronised di into the 16-bit ISR and increment the bit counter.
REQ-020 MSB first: ISR[15:0] <= {ISR[14:0], di}; in 8-bit mode only ISR[7:0] is used.
REQ-021 LSB first, 16-bit: ISR <= {di, ISR[15:1]}; LSB first, 8-bit: ISR[7:0] <= {di, ISR[7:1]}.
REQ-022 On the Nth sample (N=16 or 8), same cycle: sdx_dout <= assembled word (8-bit: upper byte zero); ibf <= 1; state -> IDLE.
REQ-023 Transfer while ibf=1 and no concurrent read SHALL overwrite sdx_dout and set ovr=1.
REQ-024 sdx_read with cen=1 SHALL clear ibf and ovr on the next clk edge; sdx_read with cen=0 SHALL be ignored.
REQ-025 Read and transfer in the same cycle: transfer wins; sdx_dout updates, ibf stays 1, ovr unchanged.
REQ-026 ild rising edge while in SHIFT SHALL restart the frame per REQ-017; the partial word is discarded and ibf/ovr are unchanged.
REQ-027 ild and ick rising edges in the same cycle while in SHIFT: restart wins and the ick sample is discarded; in IDLE: enter SHIFT and discard the sample.
REQ-028 Latency: ibf and sdx_dout SHALL be visible after the 3rd clk rising edge following the Nth ick pin rising edge (2 sync + 1 action).
REQ-029 Changes on ilen16 or lsb_first mid-frame SHALL have no effect until the next frame start.

Reset
REQ-030 rst=1 SHALL immediately force: state=IDLE, sdx_dout=0, ISR=0, bit counter=0, ibf=0, ovr=0, busy=0, all synchroniser and edge flops=0.
REQ-031 Assertion of rst mid-frame SHALL abort the frame; after release, no transfer occurs until a new ild rising edge.
REQ-032 An ild held high through rst release SHALL NOT count as an edge until it goes low then high again.

Verification
REQ-033 ilen16=1, lsb_first=0: ild pulse, then 16 ick pulses carrying 0xA5C3 MSB first -> sdx_dout=0xA5C3, ibf=1, ovr=0, 3 clk after the 16th ick rise.
REQ-034 ilen16=0, lsb_first=1: 8 ick pulses carrying bits of 0x5A LSB first -> sdx_dout=0x005A, ibf=1.
REQ-035 Two 16-bit frames (0x1234, 0xBEEF) with no sdx_read between them -> sdx_dout=0xBEEF, ibf=1, ovr=1; then sdx_read with cen=1 -> ibf=0, ovr=0.
REQ-036 ild rising edge after 5 bits of a frame, then a full 0x00FF frame -> sdx_dout=0x00FF; no transfer from the aborted frame.
REQ-037 sdx_read asserted in the same cycle as a transfer of 0x7777 with ibf=1 -> sdx_dout=0x7777, ibf=1, ovr=0.
REQ-038 rst pulse after 10 bits, then 20 ick pulses with no ild -> ibf=0, sdx_dout=0, busy=0 throughout.
